// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus datapath: fetch/execute step
// sequencing, IR decode, and a memory-ready handshake with timeout.
module control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHighIn,
  output logic        ZLowIn,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  opcode,
  output logic [15:0] reg_in,
  output logic [15:0] reg_out,
  output logic        run,
  output logic        illegal,
  output logic        mem_error
);

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_T7   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

  logic [3:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       mem_error_q, mem_error_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_rtype, is_addi, is_muldiv, is_ld, is_st, is_ldst, is_nop, is_halt;
  logic       mem_wait;
  logic       unused_c;

  assign op       = ir[31:27];
  assign ra       = ir[26:23];
  assign rb       = ir[22:19];
  assign rc       = ir[18:15];
  assign unused_c = ^ir[14:0];

  assign is_rtype  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                     (op == OP_OR)  || (op == OP_SHR) || (op == OP_SHL);
  assign is_addi   = (op == OP_ADDI);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_ld     = (op == OP_LD);
  assign is_st     = (op == OP_ST);
  assign is_ldst   = is_ld || is_st;
  assign is_nop    = (op == OP_NOP);
  assign is_halt   = (op == OP_HALT);

  // R0 is hardwired, so a select of register 0 never produces a strobe.
  function automatic logic [15:0] gpr_sel(input logic [3:0] idx);
    gpr_sel = (idx == 4'd0) ? 16'h0000 : (16'h0001 << idx);
  endfunction

  assign mem_wait = (state_q == S_T1) || ((state_q == S_T6) && is_ld) ||
                    ((state_q == S_T7) && is_st);

  always_comb begin
    state_d     = state_q;
    cnt_d       = 8'd0;
    illegal_d   = illegal_q;
    mem_error_d = mem_error_q;
    case (state_q)
      S_RST: state_d = S_T0;
      S_T0:  state_d = S_T1;
      S_T1:  state_d = S_T2;
      S_T2:  state_d = S_T3;
      S_T3: begin
        if (is_rtype || is_addi || is_muldiv || is_ldst) state_d = S_T4;
        else if (is_nop)                                 state_d = S_T0;
        else if (is_halt)                                state_d = S_HALT;
        else begin
          illegal_d = 1'b1;
          state_d   = S_T0;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = (is_muldiv || is_ldst) ? S_T6 : S_T0;
      S_T6:   state_d = is_ldst ? S_T7 : S_T0;
      S_T7:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    // Wait states hold until mem_ready; the counter starts at 0 on entry.
    if (mem_wait && !mem_ready) begin
      if (({1'b0, cnt_q} + 9'd1) >= TIMEOUT) begin
        mem_error_d = 1'b1;
        state_d     = S_HALT;
      end else begin
        cnt_d   = cnt_q + 8'd1;
        state_d = state_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q     <= S_RST;
      cnt_q       <= 8'd0;
      illegal_q   <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      mem_error_q <= mem_error_d;
    end
  end

  assign run       = (state_q != S_RST) && (state_q != S_HALT);
  assign illegal   = illegal_q;
  assign mem_error = mem_error_q;

  always_comb begin
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0;
    Cout = 1'b0; BAout = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    opcode  = 5'd0;
    reg_in  = 16'h0000;
    reg_out = 16'h0000;
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_rtype || is_addi) begin
          reg_out = gpr_sel(rb); Yin = 1'b1;
        end else if (is_muldiv) begin
          reg_out = gpr_sel(ra); Yin = 1'b1;
        end else if (is_ldst) begin
          // Rb=0 means absolute addressing: drive the base-address zero instead.
          if (rb == 4'd0) BAout = 1'b1;
          else            reg_out = gpr_sel(rb);
          Yin = 1'b1;
        end
      end
      S_T4: begin
        if (is_rtype) begin
          reg_out = gpr_sel(rc); opcode = op; ZLowIn = 1'b1;
        end else if (is_addi || is_ldst) begin
          Cout = 1'b1; opcode = OP_ADD; ZLowIn = 1'b1;
        end else if (is_muldiv) begin
          reg_out = gpr_sel(rb); opcode = op; ZHighIn = 1'b1; ZLowIn = 1'b1;
        end
      end
      S_T5: begin
        if (is_rtype || is_addi) begin
          Zlowout = 1'b1; reg_in = gpr_sel(ra);
        end else if (is_muldiv) begin
          Zlowout = 1'b1; LOin = 1'b1;
        end else if (is_ldst) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end
      end
      S_T6: begin
        if (is_muldiv) begin
          Zhighout = 1'b1; HIin = 1'b1;
        end else if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          reg_out = gpr_sel(ra); MDRin = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          MDRout = 1'b1; reg_in = gpr_sel(ra);
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle vector table plus reset and
// memory-timeout sequences.
module tb_control_sequencer;

  logic        clock, clear, mem_ready;
  logic [31:0] ir;
  logic PCout, Zhighout, Zlowout, MDRout, Cout, BAout, MARin, MDRin, IRin, Yin;
  logic HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Write, run, illegal, mem_error;
  logic [4:0]  opcode;
  logic [15:0] reg_in, reg_out;
  logic [56:0] act;

  control_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .Cout(Cout), .BAout(BAout), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .IncPC(IncPC), .Read(Read), .Write(Write), .opcode(opcode),
    .reg_in(reg_in), .reg_out(reg_out), .run(run), .illegal(illegal),
    .mem_error(mem_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign act = {PCout, Zhighout, Zlowout, MDRout, Cout, BAout, MARin, MDRin, IRin,
                Yin, HIin, LOin, ZHighIn, ZLowIn, IncPC, Read, Write,
                opcode, reg_in, reg_out, run, illegal, mem_error};

  localparam logic [16:0] PCO  = 17'd1 << 16;
  localparam logic [16:0] ZHO  = 17'd1 << 15;
  localparam logic [16:0] ZLO  = 17'd1 << 14;
  localparam logic [16:0] MDRO = 17'd1 << 13;
  localparam logic [16:0] CO   = 17'd1 << 12;
  localparam logic [16:0] BAO  = 17'd1 << 11;
  localparam logic [16:0] MARI = 17'd1 << 10;
  localparam logic [16:0] MDRI = 17'd1 << 9;
  localparam logic [16:0] IRI  = 17'd1 << 8;
  localparam logic [16:0] YI   = 17'd1 << 7;
  localparam logic [16:0] HII  = 17'd1 << 6;
  localparam logic [16:0] LOI  = 17'd1 << 5;
  localparam logic [16:0] ZHI  = 17'd1 << 4;
  localparam logic [16:0] ZLI  = 17'd1 << 3;
  localparam logic [16:0] INC  = 17'd1 << 2;
  localparam logic [16:0] RD   = 17'd1 << 1;
  localparam logic [16:0] WR   = 17'd1;

  typedef struct {
    logic        clr;
    logic        rdy;
    logic [31:0] irv;
    logic [56:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic ill_e  = 1'b0;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [3:0] rc,
                                      input logic [14:0] lo);
    return {op, ra, rb, rc, lo};
  endfunction

  function automatic logic [56:0] mk(input logic [16:0] s, input logic [4:0] opc,
                                     input logic [15:0] rin, input logic [15:0] rout,
                                     input logic r, input logic il, input logic me);
    return {s, opc, rin, rout, r, il, me};
  endfunction

  task automatic v(input logic rdy, input logic [31:0] irv, input logic [16:0] s,
                   input logic [4:0] opc, input logic [15:0] rin, input logic [15:0] rout,
                   input logic r);
    vec_t e;
    e.clr = 1'b1; e.rdy = rdy; e.irv = irv;
    e.exp = mk(s, opc, rin, rout, r, ill_e, 1'b0);
    tbl.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] irv);
    v(1'b1, irv, PCO | MARI | INC, 5'd0, 16'h0, 16'h0, 1'b1);
    v(1'b1, irv, RD | MDRI,        5'd0, 16'h0, 16'h0, 1'b1);
    v(1'b1, irv, MDRO | IRI,       5'd0, 16'h0, 16'h0, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [56:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] i_add, i_nop, i_ld, i_mul, i_st, i_addi, i_add0, i_sub, i_bad, i_halt;
  int n_wait;

  initial begin
    i_add  = enc(5'b00011, 4'd5, 4'd2, 4'd3, 15'd0);
    i_nop  = enc(5'b11010, 4'd0, 4'd0, 4'd0, 15'd0);
    i_ld   = enc(5'b00000, 4'd1, 4'd0, 4'd0, 15'h10);
    i_mul  = enc(5'b01111, 4'd4, 4'd6, 4'd0, 15'd0);
    i_st   = enc(5'b00010, 4'd7, 4'd2, 4'd0, 15'd4);
    i_addi = enc(5'b01100, 4'd3, 4'd1, 4'd0, 15'd5);
    i_add0 = enc(5'b00011, 4'd0, 4'd2, 4'd3, 15'd0);
    i_sub  = enc(5'b00100, 4'd1, 4'd0, 4'd2, 15'd0);
    i_bad  = enc(5'b00001, 4'd1, 4'd2, 4'd3, 15'd0);
    i_halt = enc(5'b11011, 4'd0, 4'd0, 4'd0, 15'd0);

    // add R5,R2,R3
    fetch(i_add);
    v(1, i_add, YI,  5'd0,     16'h0,  16'h0004, 1);
    v(1, i_add, ZLI, 5'b00011, 16'h0,  16'h0008, 1);
    v(1, i_add, ZLO, 5'd0,     16'h20, 16'h0,    1);
    // fetch with mem_ready late by 3 cycles, then nop
    v(1, i_nop, PCO | MARI | INC, 5'd0, 16'h0, 16'h0, 1);
    v(0, i_nop, RD | MDRI, 5'd0, 16'h0, 16'h0, 1);
    v(0, i_nop, RD | MDRI, 5'd0, 16'h0, 16'h0, 1);
    v(0, i_nop, RD | MDRI, 5'd0, 16'h0, 16'h0, 1);
    v(1, i_nop, RD | MDRI, 5'd0, 16'h0, 16'h0, 1);
    v(1, i_nop, MDRO | IRI, 5'd0, 16'h0, 16'h0, 1);
    v(1, i_nop, 17'd0, 5'd0, 16'h0, 16'h0, 1);
    // ld R1,0x10(R0)
    fetch(i_ld);
    v(1, i_ld, BAO | YI,   5'd0,     16'h0, 16'h0, 1);
    v(1, i_ld, CO | ZLI,   5'b00011, 16'h0, 16'h0, 1);
    v(1, i_ld, ZLO | MARI, 5'd0,     16'h0, 16'h0, 1);
    v(0, i_ld, RD | MDRI,  5'd0,     16'h0, 16'h0, 1);
    v(1, i_ld, RD | MDRI,  5'd0,     16'h0, 16'h0, 1);
    v(1, i_ld, MDRO,       5'd0,     16'h2, 16'h0, 1);
    // mul R4,R6
    fetch(i_mul);
    v(1, i_mul, YI,        5'd0,     16'h0, 16'h0010, 1);
    v(1, i_mul, ZHI | ZLI, 5'b01111, 16'h0, 16'h0040, 1);
    v(1, i_mul, ZLO | LOI, 5'd0,     16'h0, 16'h0,    1);
    v(1, i_mul, ZHO | HII, 5'd0,     16'h0, 16'h0,    1);
    // st R7,4(R2)
    fetch(i_st);
    v(1, i_st, YI,         5'd0,     16'h0, 16'h0004, 1);
    v(1, i_st, CO | ZLI,   5'b00011, 16'h0, 16'h0,    1);
    v(1, i_st, ZLO | MARI, 5'd0,     16'h0, 16'h0,    1);
    v(1, i_st, MDRI,       5'd0,     16'h0, 16'h0080, 1);
    v(0, i_st, WR,         5'd0,     16'h0, 16'h0,    1);
    v(1, i_st, WR,         5'd0,     16'h0, 16'h0,    1);
    // addi R3,R1,5
    fetch(i_addi);
    v(1, i_addi, YI,       5'd0,     16'h0, 16'h0002, 1);
    v(1, i_addi, CO | ZLI, 5'b00011, 16'h0, 16'h0,    1);
    v(1, i_addi, ZLO,      5'd0,     16'h8, 16'h0,    1);
    // add R0,R2,R3: write to R0 suppressed
    fetch(i_add0);
    v(1, i_add0, YI,  5'd0,     16'h0, 16'h0004, 1);
    v(1, i_add0, ZLI, 5'b00011, 16'h0, 16'h0008, 1);
    v(1, i_add0, ZLO, 5'd0,     16'h0, 16'h0,    1);
    // sub R1,R0,R2: read of R0 suppressed
    fetch(i_sub);
    v(1, i_sub, YI,  5'd0,     16'h0, 16'h0,    1);
    v(1, i_sub, ZLI, 5'b00100, 16'h0, 16'h0004, 1);
    v(1, i_sub, ZLO, 5'd0,     16'h2, 16'h0,    1);
    // unknown opcode, then halt
    fetch(i_bad);
    v(1, i_bad, 17'd0, 5'd0, 16'h0, 16'h0, 1);
    ill_e = 1'b1;
    fetch(i_halt);
    v(1, i_halt, 17'd0, 5'd0, 16'h0, 16'h0, 1);
    v(0, i_halt, 17'd0, 5'd0, 16'h0, 16'h0, 0);
    v(1, i_halt, 17'd0, 5'd0, 16'h0, 16'h0, 0);

    clear = 1'b0; mem_ready = 1'b0; ir = 32'd0;
    tick(); tick();
    clear = 1'b1;
    @(negedge clock);
    chk("reset_state", 57'd0);
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      clear = tbl[i].clr; mem_ready = tbl[i].rdy; ir = tbl[i].irv;
      @(negedge clock);
      chk($sformatf("vec%0d", i), tbl[i].exp);
      tick();
    end

    // Reset in the middle of an add (T4), held two cycles
    clear = 1'b0; tick();
    clear = 1'b1; tick();
    ir = i_add; mem_ready = 1'b1;
    repeat (4) tick();
    @(negedge clock);
    chk("pre_reset_T4", mk(ZLI, 5'b00011, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b0));
    clear = 1'b0; tick();
    @(negedge clock);
    chk("reset_mid_1", 57'd0);
    tick();
    @(negedge clock);
    chk("reset_mid_2", 57'd0);
    clear = 1'b1; tick();
    @(negedge clock);
    chk("reset_exit_T0", mk(PCO | MARI | INC, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0));

    // Memory never answers in T1
    mem_ready = 1'b0;
    tick();
    n_wait = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (!run) break;
      if (Read && MDRin) n_wait++;
      tick();
    end
    chk("timeout_halt", mk(17'd0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1));
    checks++;
    if (n_wait != 4) begin
      errors++;
      $display("FAIL timeout_wait_cycles actual=%0d required=4", n_wait);
    end
    mem_ready = 1'b1;
    repeat (3) tick();
    @(negedge clock);
    chk("timeout_sticky", mk(17'd0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1));
    clear = 1'b0; tick();
    @(negedge clock);
    chk("timeout_clear", 57'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
